// File: rtl/call_dispatcher.sv
// Pending-call latch and SCAN-ordered dispatcher feeding one floor at a time
// to the elevator controller's button input.
module call_dispatcher #(
    parameter int ISSUE_TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] call_req,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       door_open,
    output logic [2:0] button,
    output logic [6:0] pending,
    output logic       dir_up,
    output logic [2:0] cur_floor
);
    typedef enum logic [1:0] {
        D_IDLE       = 2'd0,
        D_ISSUE      = 2'd1,
        D_WAIT_CLOSE = 2'd2
    } state_t;

    localparam logic [5:0] TIMEOUT = 6'(ISSUE_TIMEOUT);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic [2:0] button_nxt, cur_nxt, tgt;
    logic [6:0] pending_nxt, req_mask, clr_mask;
    logic       dir_nxt, tgt_dir, quiet;
    logic       at_cur, any_above, any_below;
    logic [2:0] lo_above, hi_below;

    assign quiet = !move_up && !move_down;

    // Nearest pending floor on each side of the current floor.
    always_comb begin
        at_cur    = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        lo_above  = '0;
        hi_below  = '0;
        for (int f = 7; f >= 1; f--) begin
            if (pending[f-1] && f > int'(cur_floor)) begin
                lo_above  = 3'(f);
                any_above = 1'b1;
            end
        end
        for (int f = 1; f <= 7; f++) begin
            if (pending[f-1]) begin
                if (f == int'(cur_floor)) at_cur = 1'b1;
                if (f < int'(cur_floor)) begin
                    hi_below  = 3'(f);
                    any_below = 1'b1;
                end
            end
        end
    end

    // SCAN: keep sweeping while calls remain ahead, otherwise reverse.
    always_comb begin
        tgt     = cur_floor;
        tgt_dir = dir_up;
        if (!at_cur) begin
            if (dir_up) begin
                if (any_above) tgt = lo_above;
                else begin
                    tgt     = hi_below;
                    tgt_dir = 1'b0;
                end
            end else begin
                if (any_below) tgt = hi_below;
                else begin
                    tgt     = lo_above;
                    tgt_dir = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        button_nxt = button;
        dir_nxt    = dir_up;
        cur_nxt    = cur_floor;
        cnt_nxt    = cnt;
        req_mask   = call_req;
        clr_mask   = '0;
        case (state)
            D_IDLE: begin
                button_nxt = '0;
                if (pending != '0 && quiet && !door_open) begin
                    button_nxt = tgt;
                    dir_nxt    = tgt_dir;
                    cnt_nxt    = '0;
                    state_nxt  = D_ISSUE;
                end
            end
            D_ISSUE: begin
                if (door_open) begin
                    cur_nxt    = button;
                    clr_mask   = 7'b1 << (button - 3'd1);
                    button_nxt = '0;
                    state_nxt  = D_WAIT_CLOSE;
                end else if (cnt == TIMEOUT) begin
                    button_nxt = '0;
                    state_nxt  = D_IDLE;
                end else if (quiet) begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            D_WAIT_CLOSE: begin
                button_nxt = '0;
                // The door is open at this floor; a press here is already served.
                req_mask   = call_req & ~(7'b1 << (cur_floor - 3'd1));
                if (!door_open) state_nxt = D_IDLE;
            end
            default: begin
                button_nxt = '0;
                state_nxt  = D_IDLE;
            end
        endcase
        pending_nxt = (pending | req_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= D_IDLE;
            button    <= '0;
            pending   <= '0;
            dir_up    <= 1'b1;
            cur_floor <= 3'd1;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            button    <= button_nxt;
            pending   <= pending_nxt;
            dir_up    <= dir_nxt;
            cur_floor <= cur_nxt;
            cnt       <= cnt_nxt;
        end
    end
endmodule

// File: doc/call_dispatcher.md
# call_dispatcher

Latches floor-call requests from car and hall buttons and holds them as pending calls. Dispatches them one at a time to the elevator controller as a 3-bit floor number, using SCAN (elevator-algorithm) ordering. Sits directly upstream of the elevator controller: its `button` output drives the controller's `button` input, and it watches the controller's `move_up`, `move_down` and `door_open` outputs to sequence dispatches. Floors are numbered 1..7 and encoding 0 means "no request", matching the controller.

## Interface
- `ISSUE_TIMEOUT`, 63: cycles to wait in ISSUE for `door_open` before abandoning the dispatch and retrying; range 1..63.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `call_req`  in  7  level or pulse per floor; bit i-1 = floor i; inputs are already synchronous to `clk`.
- `move_up`  in  1  from controller.
- `move_down`  in  1  from controller.
- `door_open`  in  1  from controller.
- `button`  out  3  registered floor request to controller; 0 = none.
- `pending`  out  7  registered pending-call mask (lamp drive); bit i-1 = floor i.
- `dir_up`  out  1  registered current sweep direction; 1 = up.
- `cur_floor`  out  3  registered last served floor.

## Operation
- Reset values: `button`=0, `pending`=0, `dir_up`=1, `cur_floor`=1, state=D_IDLE, timeout counter=0.
- Call capture:
  - Every cycle, `pending <= (pending | call_req) & ~clr_mask`.
  - `clr_mask` is the served-floor bit in the clearing cycle; clear wins over a simultaneous set of the same bit.
  - In D_WAIT_CLOSE, `call_req` for `cur_floor` is discarded.
  - A button still held after the door closes re-registers and is served again.
- Target selection (combinational, from registered `pending`, `cur_floor`, `dir_up`):
  - Pending bit at `cur_floor` → target = `cur_floor`, direction unchanged.
  - Else if `dir_up`: any pending above → lowest above; otherwise highest below and clear `dir_up`.
  - Else (down): any pending below → highest below; otherwise lowest above and set `dir_up`.
  - `dir_up` updates only when a dispatch is issued.
- State machine:
  - D_IDLE: `button`=0. If `pending`≠0 and `move_up`=`move_down`=`door_open`=0, load `button`<=target, load the `dir_up` update, clear the timeout counter, go to D_ISSUE.
  - D_ISSUE: hold `button`. Each cycle:
    - If `door_open`=1: `cur_floor`<=`button`, clear that pending bit, `button`<=0, go to D_WAIT_CLOSE.
    - Else if the counter = `ISSUE_TIMEOUT`: `button`<=0, go to D_IDLE; the pending bit is retained.
    - Else: increment the counter, but only while `move_up`=`move_down`=0 (travel time is not counted).
  - D_WAIT_CLOSE: `button`=0. When `door_open`=0, go to D_IDLE.
  - Illegal state encoding → D_IDLE with `button`=0.
- The controller gives `button` priority over manual door-open in its idle state. A manual door-open that begins before a dispatch blocks D_IDLE, so no dispatch is issued while the door is open.
- Reset mid-operation: every register returns to its reset value on the next edge and all pending calls are lost. The controller is reset by the same `rst`.

## Timing
- Latency from `call_req` to `button`: `call_req` high in cycle 0 → `pending` bit set in cycle 1 → `button` valid in cycle 2, provided the controller is quiet.
- `button` is stable for the whole of D_ISSUE and is 0 in every other state. The controller therefore samples only one nonzero value per dispatch.
- Served at current floor: the controller takes 2 cycles (IDLE→BUTTON_PRESS→DOOR_OPEN). `door_open` is seen in the 3rd D_ISSUE cycle, and the pending bit clears on the following edge.
- Arithmetic: `cur_floor` and `button` are 3 bits, and values 1..7 only are ever loaded. The timeout counter is 6 bits, compared with `==`, and never wraps.
- Minimum spacing between dispatches: the D_WAIT_CLOSE exit plus 1 D_IDLE cycle.

## Test plan
- Reset → `button`=0, `pending`=0, `dir_up`=1, `cur_floor`=1; hold `rst` for 3 cycles mid-D_ISSUE → same values.
- `cur_floor`=1, pulse `call_req`=7'b0001000 → `button`=4 two cycles later, held through travel; on `door_open`, `pending`→0, `cur_floor`=4, `button`=0.
- `cur_floor`=3, `dir_up`=1, `pending`={floor 2, floor 5} → dispatch 5 first, then 2 with `dir_up`=0.
- Call for `cur_floor`=3 with the door closed → `button`=3, served via `door_open` with no move; a call for floor 3 during D_WAIT_CLOSE → `pending` stays 0.
- `ISSUE_TIMEOUT`=4 with the controller model never asserting anything → `button` drops to 0 after 5 D_ISSUE cycles, the pending bit is retained, and a re-issue follows.
- Simultaneous `call_req` for the served floor in the `door_open` clearing cycle → bit cleared; with `move_up`=1 in D_IDLE → no dispatch until the controller is quiet.
